// File: rtl/count_seq_ctrl_pkg.sv
// count_pkg: shared state encoding and direction constants for the count sequencer
package count_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} cseq_state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/count_seq_ctrl_if.sv
// count_seq_ctrl_if: job request and counter status bundle between host and sequencer
interface count_seq_ctrl_if #(parameter int W = 4);
  logic start;
  logic dir;
  logic [W-1:0] init_val;
  logic [W-1:0] steps;
  logic pause;
  logic [W-1:0] cnt_val;
  logic busy;
  logic done;
  logic wrap;
  modport master (output start, dir, init_val, steps, pause, input cnt_val, busy, done, wrap);
  modport slave (input start, dir, init_val, steps, pause, output cnt_val, busy, done, wrap);
endinterface

// File: rtl/count_seq_ctrl_cnt.sv
// updown_cnt: loadable modulo-2^W up/down counter with a registered wrap pulse
module updown_cnt import count_pkg::*; #(parameter int W = 4) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         dir,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  // reset beats load beats step; wrap flags a step that crossed the modulo boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      wrap <= 1'b0;
    end else if (en) begin
      cnt <= (dir == DIR_UP) ? cnt + 1'b1 : cnt - 1'b1;
      wrap <= (dir == DIR_UP) ? &cnt : ~|cnt;
    end else begin
      wrap <= 1'b0;
    end
  end
endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: sequences the counter through load-then-step runs with pause
module count_seq_ctrl import count_pkg::*; #(parameter int W = 4) (
  input  logic clk,
  input  logic reset,
  count_seq_ctrl_if.slave bus
);
  cseq_state_t state;
  logic dir_cap;
  logic [W-1:0] init_cap;
  logic [W-1:0] steps_cap;
  logic [W-1:0] remaining;
  logic [W-1:0] cnt;
  logic wrap;
  logic busy;
  logic done;
  logic load;
  logic en;
  assign load = (state == LOAD);
  assign en = (state == RUN) && !bus.pause;
  assign bus.cnt_val = cnt;
  assign bus.wrap = wrap;
  assign bus.busy = busy;
  assign bus.done = done;
  updown_cnt #(.W(W)) u_cnt (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(init_cap),
    .en(en),
    .dir(dir_cap),
    .cnt(cnt),
    .wrap(wrap)
  );
  // job FSM; busy/done are registered alongside the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dir_cap <= 1'b0;
      init_cap <= '0;
      steps_cap <= '0;
      remaining <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          dir_cap <= bus.dir;
          init_cap <= bus.init_val;
          steps_cap <= bus.steps;
          state <= LOAD;
          busy <= 1'b1;
        end
        LOAD: begin
          remaining <= steps_cap;
          state <= (steps_cap == '0) ? DONE : RUN;
          busy <= (steps_cap != '0);
          done <= (steps_cap == '0);
        end
        RUN: if (!bus.pause) begin
          remaining <= remaining - 1'b1;
          if (remaining == W'(1)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed jobs with a per-cycle expected-output scoreboard
module tb_count_seq_ctrl;
  typedef struct {
    logic [3:0] c;
    logic b;
    logic d;
    logic w;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];
  logic [3:0] last = 4'd0;
  string tag;
  count_seq_ctrl_if #(.W(4)) bus ();
  count_seq_ctrl #(.W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic push(input logic [3:0] c, input logic b, input logic d, input logic w);
    exp_t e;
    e.c = c;
    e.b = b;
    e.d = d;
    e.w = w;
    exp_q.push_back(e);
  endtask
  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    tests++;
    assert (exp_q.size() != 0) else begin
      fails++;
      $error("FAIL %s scoreboard empty got 0 entries exp >=1", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests++;
      assert (bus.cnt_val === e.c) else begin
        fails++;
        $error("FAIL %s cnt_val got %0d exp %0d", tag, bus.cnt_val, e.c);
      end
      tests++;
      assert (bus.busy === e.b) else begin
        fails++;
        $error("FAIL %s busy got %b exp %b", tag, bus.busy, e.b);
      end
      tests++;
      assert (bus.done === e.d) else begin
        fails++;
        $error("FAIL %s done got %b exp %b", tag, bus.done, e.d);
      end
      tests++;
      assert (bus.wrap === e.w) else begin
        fails++;
        $error("FAIL %s wrap got %b exp %b", tag, bus.wrap, e.w);
      end
    end
  endtask
  task automatic rst_rand(input string t);
    tag = t;
    repeat (2) begin
      reset = 1'b1;
      bus.start = 1'($urandom);
      bus.dir = 1'($urandom);
      bus.init_val = 4'($urandom);
      bus.steps = 4'($urandom);
      bus.pause = 1'($urandom);
      push(4'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    reset = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    push(4'd0, 1'b0, 1'b0, 1'b0);
    step();
    last = 4'd0;
  endtask
  task automatic job(input string t, input logic d, input logic [3:0] init, input logic [3:0] n,
                     input int p_after, input int p_len, input int start_at, input int abort);
    int rst_at;
    int p_lo;
    int total;
    logic [3:0] c;
    logic w;
    tag = t;
    rst_at = -1;
    p_lo = 2 + p_after;
    push(last, 1'b1, 1'b0, 1'b0);
    push(init, n != 0, n == 0, 1'b0);
    c = init;
    for (int s = 1; s <= int'(n); s++) begin
      if (s == p_after + 1) repeat (p_len) push(c, 1'b1, 1'b0, 1'b0);
      if (abort != 0 && s == abort + 1) begin
        rst_at = exp_q.size();
        push(4'd0, 1'b0, 1'b0, 1'b0);
        c = 4'd0;
        break;
      end
      w = d ? (c == 4'd15) : (c == 4'd0);
      c = d ? c + 4'd1 : c - 4'd1;
      push(c, s != int'(n), s == int'(n), w);
    end
    push(c, 1'b0, 1'b0, 1'b0);
    last = c;
    total = exp_q.size();
    for (int i = 0; i < total; i++) begin
      bus.start = (i == 0) || (i == start_at);
      bus.dir = (i == 0) ? d : ~d;
      bus.init_val = (i == 0) ? init : ~init;
      bus.steps = (i == 0) ? n : 4'd7;
      bus.pause = (p_len > 0) && (i >= p_lo) && (i < p_lo + p_len);
      reset = (i == rst_at);
      step();
    end
    reset = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL %s leftover got %0d exp 0", tag, exp_q.size());
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.dir = 1'b0;
    bus.init_val = 4'd0;
    bus.steps = 4'd0;
    bus.pause = 1'b0;
    rst_rand("reset_init");
    job("up_run", 1'b1, 4'd3, 4'd5, 0, 0, -1, 0);
    rst_rand("reset_idle");
    job("down_wrap", 1'b0, 4'd1, 4'd3, 0, 0, -1, 0);
    job("zero_steps", 1'b1, 4'd9, 4'd0, 0, 0, -1, 0);
    job("pause_ign_start", 1'b1, 4'd14, 4'd4, 1, 3, 4, 0);
    job("reset_mid_run", 1'b1, 4'd2, 4'd10, 0, 0, -1, 4);
    job("after_reset", 1'b0, 4'd5, 4'd2, 0, 0, -1, 0);
    job("full_range", 1'b1, 4'd15, 4'd15, 0, 0, -1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
